// File: rtl/lol_stream_reader_if.sv
// rtl/lol_stream_reader_if.sv - glyph column stream in, letter/word flags out
interface lol_stream_reader_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [2:0]             bits;
  logic                   valid;
  logic                   L;
  logic                   O;
  logic                   Y;
  logic                   bad;
  logic                   lol;
  logic [COUNT_WIDTH-1:0] letter_count;

  modport master (output bits, valid, input L, O, Y, bad, lol, letter_count);
  modport slave  (input bits, valid, output L, O, Y, bad, lol, letter_count);
endinterface

// File: rtl/lol_stream_reader.sv
// rtl/lol_stream_reader.sv - continuous L/O/Y glyph column decoder with LOL word detector
module lol_stream_reader #(
  parameter int COUNT_WIDTH  = 8,
  parameter bit HOLD_OUTPUTS = 1'b0
) (
  input logic                clk,
  input logic                restart,
  lol_stream_reader_if.slave bus
);

  typedef enum logic [3:0] {BLANK, S111, L2, O2, O3, Y1, Y2, Y3, JUNK} state_t;
  typedef enum logic [1:0] {LET_NONE, LET_L, LET_O, LET_Y} letter_t;

  state_t                 state;
  letter_t                hist_old;
  letter_t                hist_new;
  letter_t                ev_letter;
  logic                   ev_bad;
  logic                   ev_lol;
  logic                   accept_blank;
  logic                   accept_mark;
  logic                   flag_l;
  logic                   flag_o;
  logic                   flag_y;
  logic                   flag_bad;
  logic                   flag_lol;
  logic [COUNT_WIDTH-1:0] count;

  assign accept_blank = bus.valid && (bus.bits == 3'b000);
  assign accept_mark  = bus.valid && (bus.bits != 3'b000);

  // A glyph is only judged when its terminating blank column is accepted.
  always_comb begin
    ev_letter = LET_NONE;
    ev_bad    = 1'b0;
    if (accept_blank) begin
      case (state)
        L2:                       ev_letter = LET_L;
        O3:                       ev_letter = LET_O;
        Y3:                       ev_letter = LET_Y;
        S111, O2, Y1, Y2, JUNK:   ev_bad    = 1'b1;
        default:                  ev_bad    = 1'b0;
      endcase
    end
  end

  assign ev_lol = (ev_letter == LET_L) && (hist_old == LET_L) && (hist_new == LET_O);

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state    <= BLANK;
      hist_old <= LET_NONE;
      hist_new <= LET_NONE;
      count    <= '0;
      flag_l   <= 1'b0;
      flag_o   <= 1'b0;
      flag_y   <= 1'b0;
      flag_bad <= 1'b0;
      flag_lol <= 1'b0;
    end else begin
      if (accept_blank) begin
        state <= BLANK;
      end else if (accept_mark) begin
        state <= JUNK;
        case (state)
          BLANK: begin
            if (bus.bits == 3'b111) state <= S111;
            else if (bus.bits == 3'b100) state <= Y1;
          end
          S111: begin
            if (bus.bits == 3'b001) state <= L2;
            else if (bus.bits == 3'b101) state <= O2;
          end
          O2:      if (bus.bits == 3'b111) state <= O3;
          Y1:      if (bus.bits == 3'b011) state <= Y2;
          Y2:      if (bus.bits == 3'b100) state <= Y3;
          default: state <= JUNK;
        endcase
      end

      if ((ev_letter != LET_NONE) || ev_bad) begin
        flag_l   <= (ev_letter == LET_L);
        flag_o   <= (ev_letter == LET_O);
        flag_y   <= (ev_letter == LET_Y);
        flag_bad <= ev_bad;
        flag_lol <= ev_lol;
      end else if (!HOLD_OUTPUTS || accept_mark) begin
        // Held flags survive idle cycles and blank-in-BLANK columns.
        flag_l   <= 1'b0;
        flag_o   <= 1'b0;
        flag_y   <= 1'b0;
        flag_bad <= 1'b0;
        flag_lol <= 1'b0;
      end

      if (ev_bad) begin
        hist_old <= LET_NONE;
        hist_new <= LET_NONE;
      end else if (ev_letter != LET_NONE) begin
        hist_old <= hist_new;
        hist_new <= ev_letter;
      end

      if ((ev_letter != LET_NONE) && (count != {COUNT_WIDTH{1'b1}})) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.L            = flag_l;
  assign bus.O            = flag_o;
  assign bus.Y            = flag_y;
  assign bus.bad          = flag_bad;
  assign bus.lol          = flag_lol;
  assign bus.letter_count = count;

endmodule

// File: tb/tb_lol_stream_reader.sv
// tb/tb_lol_stream_reader.sv - directed checks of pulse, hold and narrow-counter variants
module tb_lol_stream_reader;

  logic       clk = 1'b0;
  logic       restart = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] bits = 3'b000;
  int         total = 0;
  int         nbad = 0;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_L    = 5'b10000;
  localparam logic [4:0] F_O    = 5'b01000;
  localparam logic [4:0] F_Y    = 5'b00100;
  localparam logic [4:0] F_BAD  = 5'b00010;
  localparam logic [4:0] F_LOL  = 5'b00001;

  always #5 clk = ~clk;

  lol_stream_reader_if #(.COUNT_WIDTH(8)) bus_p ();
  lol_stream_reader_if #(.COUNT_WIDTH(8)) bus_h ();
  lol_stream_reader_if #(.COUNT_WIDTH(2)) bus_c ();

  assign bus_p.bits  = bits;
  assign bus_p.valid = valid;
  assign bus_h.bits  = bits;
  assign bus_h.valid = valid;
  assign bus_c.bits  = bits;
  assign bus_c.valid = valid;

  lol_stream_reader #(.COUNT_WIDTH(8), .HOLD_OUTPUTS(1'b0)) dut_p (
    .clk(clk), .restart(restart), .bus(bus_p));
  lol_stream_reader #(.COUNT_WIDTH(8), .HOLD_OUTPUTS(1'b1)) dut_h (
    .clk(clk), .restart(restart), .bus(bus_h));
  lol_stream_reader #(.COUNT_WIDTH(2), .HOLD_OUTPUTS(1'b0)) dut_c (
    .clk(clk), .restart(restart), .bus(bus_c));

  wire [4:0] fp = {bus_p.L, bus_p.O, bus_p.Y, bus_p.bad, bus_p.lol};
  wire [4:0] fh = {bus_h.L, bus_h.O, bus_h.Y, bus_h.bad, bus_h.lol};
  wire [4:0] fc = {bus_c.L, bus_c.O, bus_c.Y, bus_c.bad, bus_c.lol};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic col(input logic [2:0] b);
    bits  = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Idle cycles present a non-blank pattern that would derail the FSM if consumed.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bits  = 3'b010;
      valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic glyph_l();
    col(3'b111); col(3'b001); col(3'b000);
  endtask

  task automatic glyph_o();
    col(3'b111); col(3'b101); col(3'b111); col(3'b000);
  endtask

  initial begin
    #12;
    check("reset_flags_p", 32'(fp), 32'(F_NONE));
    check("reset_flags_h", 32'(fh), 32'(F_NONE));
    check("reset_count_p", 32'(bus_p.letter_count), 32'd0);
    check("reset_count_c", 32'(bus_c.letter_count), 32'd0);
    restart = 1'b1;

    // L glyph, then one idle cycle: pulse drops, held flag stays
    col(3'b111);
    check("l_col1", 32'(fp), 32'(F_NONE));
    col(3'b001);
    check("l_col2", 32'(fp), 32'(F_NONE));
    col(3'b000);
    check("l_fire_p", 32'(fp), 32'(F_L));
    check("l_fire_h", 32'(fh), 32'(F_L));
    check("l_count_p", 32'(bus_p.letter_count), 32'd1);
    check("l_count_c", 32'(bus_c.letter_count), 32'd1);
    idle(1);
    check("l_pulse_drop", 32'(fp), 32'(F_NONE));
    check("l_hold_idle", 32'(fh), 32'(F_L));

    // Blank in BLANK fires nothing and keeps held flag; then O and Y back to back
    col(3'b000);
    check("blank_blank_p", 32'(fp), 32'(F_NONE));
    check("blank_blank_h", 32'(fh), 32'(F_L));
    col(3'b111);
    check("hold_clear", 32'(fh), 32'(F_NONE));
    col(3'b101); col(3'b111); col(3'b000);
    check("o_fire_p", 32'(fp), 32'(F_O));
    check("o_count_p", 32'(bus_p.letter_count), 32'd2);
    check("o_count_c", 32'(bus_c.letter_count), 32'd2);
    col(3'b100);
    check("o_pulse_drop", 32'(fp), 32'(F_NONE));
    col(3'b011); col(3'b100); col(3'b000);
    check("y_fire_p", 32'(fp), 32'(F_Y));
    check("y_count_p", 32'(bus_p.letter_count), 32'd3);
    check("y_count_c", 32'(bus_c.letter_count), 32'd3);

    // Word detector: history (O,Y) then L,O,L,O,L fires lol on the 2nd and 3rd L
    glyph_l();
    check("w1_l_nolol", 32'(fp), 32'(F_L));
    check("w1_count_c_sat", 32'(bus_c.letter_count), 32'd3);
    glyph_o();
    check("w2_o", 32'(fp), 32'(F_O));
    glyph_l();
    check("w3_lol_p", 32'(fp), 32'(F_L | F_LOL));
    check("w3_lol_h", 32'(fh), 32'(F_L | F_LOL));
    check("w3_count_p", 32'(bus_p.letter_count), 32'd6);
    glyph_o();
    glyph_l();
    check("w5_lol_again", 32'(fp), 32'(F_L | F_LOL));
    check("w5_count_p", 32'(bus_p.letter_count), 32'd8);
    check("w5_count_c_sat", 32'(bus_c.letter_count), 32'd3);

    // O puts history at (L,O); bad must clear it so the next L is plain
    glyph_o();
    col(3'b111); col(3'b011); col(3'b000);
    check("bad_fire_p", 32'(fp), 32'(F_BAD));
    check("bad_fire_h", 32'(fh), 32'(F_BAD));
    check("bad_count", 32'(bus_p.letter_count), 32'd9);
    glyph_l();
    check("after_bad_l_nolol", 32'(fp), 32'(F_L));
    check("after_bad_count", 32'(bus_p.letter_count), 32'd10);

    // O with 3-cycle valid gaps between columns
    col(3'b111); idle(3);
    col(3'b101); idle(3);
    col(3'b111); idle(3);
    check("gap_no_early", 32'(fp), 32'(F_NONE));
    col(3'b000);
    check("gap_o_p", 32'(fp), 32'(F_O));
    check("gap_count", 32'(bus_p.letter_count), 32'd11);
    idle(3);
    check("gap_o_pulse_gone", 32'(fp), 32'(F_NONE));
    check("gap_o_held", 32'(fh), 32'(F_O));
    col(3'b111);
    check("gap_hold_clear", 32'(fh), 32'(F_NONE));
    col(3'b001); col(3'b000);
    check("gap_then_lol", 32'(fp), 32'(F_L | F_LOL));
    check("gap_then_count", 32'(bus_p.letter_count), 32'd12);

    // Async reset mid-glyph, then 001,000 must decode from BLANK as bad
    col(3'b111);
    #2;
    restart = 1'b0;
    #1;
    check("async_count_p", 32'(bus_p.letter_count), 32'd0);
    check("async_count_c", 32'(bus_c.letter_count), 32'd0);
    check("async_flags_c", 32'(fc), 32'(F_NONE));
    #2;
    restart = 1'b1;
    @(posedge clk);
    #1;
    col(3'b001); col(3'b000);
    check("post_reset_bad", 32'(fp), 32'(F_BAD));
    check("post_reset_count", 32'(bus_p.letter_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
